id_stage: RTL and testbench

Instruction-decode stage sitting directly downstream of the instruction-fetch unit: it accepts 32-bit RV32I instruction words over a valid/ready handshake and buffers them in a two-entry skid buffer. It decodes each word into register indices, a sign-extended immediate, an ALU operation and control flags, and presents the decoded bundle as a registered output toward the execute stage. It also keeps a count of decoded instructions for debug.

---
 rtl/rv32_pkg.sv | 61 ++++++
 rtl/id_stage_if.sv | 37 +++
 rtl/rv32i_decoder.sv | 114 +++++++++++
 rtl/id_stage.sv | 90 +++++++++
 tb/tb_id_stage.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - RV32I opcode constants, ALU op encodings and decoded-bundle type
// Shared by the decoder, the id_stage handshake logic and its interface.
package rv32_pkg;
    localparam int XLEN  = 32;
    localparam int REG_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef struct packed {
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  imm;
        logic [3:0]       alu_op;
        logic             reg_we;
        logic             mem_rd;
        logic             mem_wr;
        logic             branch;
        logic             jump;
        logic             alu_src_imm;
        logic             illegal;
    } dec_bundle_t;

    // alt selects SUB/SRA; callers only pass it where funct7 bit 30 is meaningful
    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction
endpackage

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - fetch-side and execute-side handshake bundle of id_stage
// slave is the decode stage, master is whoever drives fetch words and consumes bundles.
interface id_stage_if #(
    parameter int CNT_W = 32
);
    logic             flush;
    logic             in_valid;
    logic [31:0]      instr_word;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [31:0]      imm;
    logic [3:0]       alu_op;
    logic             reg_we;
    logic             mem_rd;
    logic             mem_wr;
    logic             branch;
    logic             jump;
    logic             alu_src_imm;
    logic             illegal;
    logic [CNT_W-1:0] dec_count;

    modport slave (
        input  flush, in_valid, instr_word, out_ready,
        output in_ready, out_valid, rs1, rs2, rd, imm, alu_op,
               reg_we, mem_rd, mem_wr, branch, jump, alu_src_imm, illegal, dec_count
    );

    modport master (
        output flush, in_valid, instr_word, out_ready,
        input  in_ready, out_valid, rs1, rs2, rd, imm, alu_op,
               reg_we, mem_rd, mem_wr, branch, jump, alu_src_imm, illegal, dec_count
    );
endinterface

// File: rtl/rv32i_decoder.sv
// rtl/rv32i_decoder.sv - combinational RV32I word to decoded-bundle translation
// ID_ILLEGAL_CHECK_EN: flag unrecognised encodings as illegal instead of decoding them as NOP.
module rv32i_decoder
    import rv32_pkg::*;
(
    input  logic [31:0] instr,
    output dec_bundle_t bundle
);
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    dec_bundle_t d;
    logic        bad;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        d   = '0;
        bad = 1'b0;
        case (opcode)
            OPC_OP: begin
                d.rs1    = instr[19:15];
                d.rs2    = instr[24:20];
                d.rd     = instr[11:7];
                d.reg_we = 1'b1;
                d.alu_op = alu_from_f3(f3, instr[30]);
                bad = !((f7 == 7'b0000000) ||
                        (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                d.rs1         = instr[19:15];
                d.rd          = instr[11:7];
                d.imm         = imm_i;
                d.reg_we      = 1'b1;
                d.alu_src_imm = 1'b1;
                // only the right shift has an alternate form; ADDI never becomes SUB
                d.alu_op = alu_from_f3(f3, (f3 == 3'b101) && instr[30]);
                bad = (f3 == 3'b001 && f7 != 7'b0000000) ||
                      (f3 == 3'b101 && f7 != 7'b0000000 && f7 != 7'b0100000);
            end
            OPC_LOAD: begin
                d.rs1         = instr[19:15];
                d.rd          = instr[11:7];
                d.imm         = imm_i;
                d.reg_we      = 1'b1;
                d.mem_rd      = 1'b1;
                d.alu_src_imm = 1'b1;
                bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            OPC_STORE: begin
                d.rs1         = instr[19:15];
                d.rs2         = instr[24:20];
                d.imm         = imm_s;
                d.mem_wr      = 1'b1;
                d.alu_src_imm = 1'b1;
                bad = (f3 > 3'b010);
            end
            OPC_BRANCH: begin
                d.rs1    = instr[19:15];
                d.rs2    = instr[24:20];
                d.imm    = imm_b;
                d.branch = 1'b1;
                d.alu_op = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                bad = (f3[2:1] == 2'b01);
            end
            OPC_JAL: begin
                d.rd          = instr[11:7];
                d.imm         = imm_j;
                d.reg_we      = 1'b1;
                d.jump        = 1'b1;
                d.alu_src_imm = 1'b1;
            end
            OPC_JALR: begin
                d.rs1         = instr[19:15];
                d.rd          = instr[11:7];
                d.imm         = imm_i;
                d.reg_we      = 1'b1;
                d.jump        = 1'b1;
                d.alu_src_imm = 1'b1;
                bad = (f3 != 3'b000);
            end
            OPC_LUI: begin
                d.rd          = instr[11:7];
                d.imm         = imm_u;
                d.reg_we      = 1'b1;
                d.alu_src_imm = 1'b1;
                d.alu_op      = ALU_PASSB;
            end
            OPC_AUIPC: begin
                d.rd          = instr[11:7];
                d.imm         = imm_u;
                d.reg_we      = 1'b1;
                d.alu_src_imm = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            d = '0;
`ifdef ID_ILLEGAL_CHECK_EN
            d.illegal = 1'b1;
`endif
        end
    end

    assign bundle = d;
endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage with output + skid register and handoff counter
// Words are decoded on entry; the two storage entries hold finished bundles.
module id_stage
    import rv32_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input logic        clk,
    input logic        rst,
    id_stage_if.slave  bus
);
    dec_bundle_t      dec;
    dec_bundle_t      out_q, out_d, skid_q, skid_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, handoff;

    rv32i_decoder u_dec (
        .instr  (bus.instr_word),
        .bundle (dec)
    );

    always_comb begin
        accept       = bus.in_valid && !skid_valid_q;
        handoff      = out_valid_q && bus.out_ready;
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;
        if (bus.flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (handoff) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (!out_valid_q || bus.out_ready) begin
                // skid only holds data while in_ready is low, so it never competes with accept
                if (skid_valid_q) begin
                    out_d        = skid_q;
                    out_valid_d  = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (accept) begin
                    out_d       = dec;
                    out_valid_d = 1'b1;
                end else begin
                    out_valid_d = 1'b0;
                end
            end else if (accept) begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.in_ready    = !skid_valid_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.rs1         = out_q.rs1;
    assign bus.rs2         = out_q.rs2;
    assign bus.rd          = out_q.rd;
    assign bus.imm         = out_q.imm[XLEN-1:0];
    assign bus.alu_op      = out_q.alu_op;
    assign bus.reg_we      = out_q.reg_we;
    assign bus.mem_rd      = out_q.mem_rd;
    assign bus.mem_wr      = out_q.mem_wr;
    assign bus.branch      = out_q.branch;
    assign bus.jump        = out_q.jump;
    assign bus.alu_src_imm = out_q.alu_src_imm;
    assign bus.illegal     = out_q.illegal;
    assign bus.dec_count   = cnt_q;
endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - scoreboard bench for id_stage with directed RV32I vectors
// Honours ID_ILLEGAL_CHECK_EN for the all-zero word expectation.
module tb_id_stage;
    import rv32_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    dec_bundle_t exp_q[$];

    always #5 clk = ~clk;

    id_stage_if #(.CNT_W(32)) bus ();

    id_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    // fl = {reg_we, mem_rd, mem_wr, branch, jump, alu_src_imm}
    function automatic dec_bundle_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [4:0] rd, input logic [31:0] imm,
                                       input logic [3:0] alu, input logic [5:0] fl,
                                       input logic ill);
        dec_bundle_t b;
        b.rs1 = rs1; b.rs2 = rs2; b.rd = rd; b.imm = imm; b.alu_op = alu;
        {b.reg_we, b.mem_rd, b.mem_wr, b.branch, b.jump, b.alu_src_imm} = fl;
        b.illegal = ill;
        return b;
    endfunction

    function automatic logic [31:0] addi_word(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'h13};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] w, input dec_bundle_t e);
        int n;
        n = 0;
        bus.in_valid   = 1'b1;
        bus.instr_word = w;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!bus.in_ready) begin
            failures++;
            $display("FAIL accept_timeout word=%h got=in_ready0 want=in_ready1", w);
            bus.in_valid = 1'b0;
        end else begin
            exp_q.push_back(e);
            tick();
        end
    endtask

    // monitor: every handoff pops the oldest expected bundle
    initial begin
        dec_bundle_t obs, e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                obs.rs1 = bus.rs1; obs.rs2 = bus.rs2; obs.rd = bus.rd; obs.imm = bus.imm;
                obs.alu_op = bus.alu_op; obs.reg_we = bus.reg_we; obs.mem_rd = bus.mem_rd;
                obs.mem_wr = bus.mem_wr; obs.branch = bus.branch; obs.jump = bus.jump;
                obs.alu_src_imm = bus.alu_src_imm; obs.illegal = bus.illegal;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL handoff_unexpected got=%h want=none", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        failures++;
                        $display("FAIL handoff_bundle got=%h want=%h", obs, e);
                    end
                end
            end
        end
    end

    initial begin
        dec_bundle_t ill_exp;
`ifdef ID_ILLEGAL_CHECK_EN
        ill_exp = mk(5'd0, 5'd0, 5'd0, 32'h0, ALU_ADD, 6'b000000, 1'b1);
`else
        ill_exp = mk(5'd0, 5'd0, 5'd0, 32'h0, ALU_ADD, 6'b000000, 1'b0);
`endif
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.instr_word = 32'h0; bus.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_dec_count", 64'(bus.dec_count), 64'd0);
        chk("rst_imm", 64'(bus.imm), 64'd0);
        chk("rst_illegal", 64'(bus.illegal), 64'd0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();

        send(32'h00500093, mk(5'd0, 5'd0, 5'd1, 32'h5, ALU_ADD, 6'b100001, 1'b0));
        chk("addi_latency", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b0;
        tick();
        chk("count_addi", 64'(bus.dec_count), 64'd1);

        send(32'h40208133, mk(5'd1, 5'd2, 5'd2, 32'h0, ALU_SUB, 6'b100000, 1'b0));
        send(32'h123450B7, mk(5'd0, 5'd0, 5'd1, 32'h12345000, ALU_PASSB, 6'b100001, 1'b0));
        send(32'hFE000EE3, mk(5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, ALU_SUB, 6'b000100, 1'b0));
        send(32'h00512423, mk(5'd2, 5'd5, 5'd0, 32'h8, ALU_ADD, 6'b001001, 1'b0));
        send(32'h008000EF, mk(5'd0, 5'd0, 5'd1, 32'h8, ALU_ADD, 6'b100011, 1'b0));
        bus.in_valid = 1'b0;
        repeat (2) tick();
        chk("count_stream", 64'(bus.dec_count), 64'd6);

        bus.out_ready = 1'b0;
        send(addi_word(5'd10, 12'd10), mk(5'd0, 5'd0, 5'd10, 32'd10, ALU_ADD, 6'b100001, 1'b0));
        send(addi_word(5'd11, 12'd11), mk(5'd0, 5'd0, 5'd11, 32'd11, ALU_ADD, 6'b100001, 1'b0));
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b1;
        bus.instr_word = addi_word(5'd12, 12'd12);
        tick();
        chk("bp_still_full", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        send(addi_word(5'd12, 12'd12), mk(5'd0, 5'd0, 5'd12, 32'd12, ALU_ADD, 6'b100001, 1'b0));
        send(addi_word(5'd13, 12'd13), mk(5'd0, 5'd0, 5'd13, 32'd13, ALU_ADD, 6'b100001, 1'b0));
        bus.in_valid = 1'b0;
        repeat (4) tick();
        chk("bp_count", 64'(bus.dec_count), 64'd10);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);

        bus.out_ready = 1'b0;
        send(addi_word(5'd14, 12'd14), mk(5'd0, 5'd0, 5'd14, 32'd14, ALU_ADD, 6'b100001, 1'b0));
        send(addi_word(5'd15, 12'd15), mk(5'd0, 5'd0, 5'd15, 32'd15, ALU_ADD, 6'b100001, 1'b0));
        bus.in_valid = 1'b1;
        bus.instr_word = addi_word(5'd16, 12'd16);
        bus.flush = 1'b1;
        exp_q.delete();
        tick();
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        chk("flush_count", 64'(bus.dec_count), 64'd10);
        bus.out_ready = 1'b1;
        repeat (3) tick();
        chk("flush_stays_empty", 64'(bus.out_valid), 64'd0);

        send(32'h00000000, ill_exp);
        bus.in_valid = 1'b0;
        repeat (2) tick();
        chk("illegal_count", 64'(bus.dec_count), 64'd11);

        bus.out_ready = 1'b0;
        send(addi_word(5'd20, 12'd20), mk(5'd0, 5'd0, 5'd20, 32'd20, ALU_ADD, 6'b100001, 1'b0));
        send(addi_word(5'd21, 12'd21), mk(5'd0, 5'd0, 5'd21, 32'd21, ALU_ADD, 6'b100001, 1'b0));
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst_count", 64'(bus.dec_count), 64'd0);
        chk("arst_rd", 64'(bus.rd), 64'd0);
        chk("arst_reg_we", 64'(bus.reg_we), 64'd0);
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        send(addi_word(5'd22, 12'h7FF), mk(5'd0, 5'd0, 5'd22, 32'h7FF, ALU_ADD, 6'b100001, 1'b0));
        bus.in_valid = 1'b0;
        repeat (2) tick();
        chk("post_rst_count", 64'(bus.dec_count), 64'd1);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
